// File: rtl/trace_replay_ctrl.sv
// Trace replay sequencer: walks trace RAM entries in order, waits for each
// entry's timestamp, then presents it on the ring injection handshake.
module trace_replay_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_entries,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [39:0]       mem_rdata,
    output logic              inj_valid,
    input  logic              inj_ready,
    output logic [3:0]        inj_src,
    output logic [3:0]        inj_dest,
    output logic [31:0]       inj_cycle,
    output logic [31:0]       now,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   inj_count,
    output logic [ADDR_W:0]   late_count,
    output logic [ADDR_W:0]   drop_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        WAIT_TIME,
        INJECT,
        DONE
    } state_t;

    localparam logic [31:0] TERM    = 32'hFFFF_FFFF;
    localparam logic [31:0] NOW_MAX = 32'hFFFF_FFFE;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   total;
    logic [ADDR_W:0]   addr_inc;
    logic [3:0]        src_q;
    logic [3:0]        dest_q;
    logic [31:0]       cyc_q;
    logic [31:0]       now_q;
    logic [ADDR_W:0]   inj_cnt_q;
    logic [ADDR_W:0]   late_cnt_q;
    logic [ADDR_W:0]   drop_cnt_q;

    logic go;
    logic is_term;
    logic is_self;
    logic is_last;
    logic drop;
    logic accept;
    logic late;
    logic advance;

    assign go       = start && !abort && (state == IDLE || state == DONE);
    assign addr_inc = {1'b0, addr} + {{ADDR_W{1'b0}}, 1'b1};
    assign is_last  = (addr_inc == total);
    assign is_term  = (mem_rdata[31:0] == TERM);
    assign is_self  = (mem_rdata[39:36] == mem_rdata[35:32]);
    assign drop     = (state == CAPTURE) && !is_term && is_self;
    assign accept   = (state == INJECT) && inj_ready;
    assign late     = (state == WAIT_TIME) && (now_q > cyc_q);
    assign advance  = drop || accept;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (go) state_nxt = (num_entries == '0) ? DONE : FETCH;
            end
            FETCH: state_nxt = CAPTURE;
            CAPTURE: begin
                if (is_term)      state_nxt = DONE;
                else if (is_self) state_nxt = is_last ? DONE : FETCH;
                else              state_nxt = WAIT_TIME;
            end
            WAIT_TIME: begin
                if (now_q >= cyc_q) state_nxt = INJECT;
            end
            INJECT: begin
                if (inj_ready) state_nxt = is_last ? DONE : FETCH;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            total  <= '0;
            src_q  <= '0;
            dest_q <= '0;
            cyc_q  <= '0;
        end else begin
            if (go) begin
                addr  <= '0;
                total <= num_entries;
            end else if (advance && !is_last) begin
                addr <= addr_inc[ADDR_W-1:0];
            end
            if (state == CAPTURE) begin
                src_q  <= mem_rdata[39:36];
                dest_q <= mem_rdata[35:32];
                cyc_q  <= mem_rdata[31:0];
            end
        end
    end

    // now stops one short of the terminator so a real timestamp is always reachable
    always_ff @(posedge clk) begin
        if (rst) begin
            now_q      <= '0;
            inj_cnt_q  <= '0;
            late_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else if (go) begin
            now_q      <= '0;
            inj_cnt_q  <= '0;
            late_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (busy && now_q != NOW_MAX)
                now_q <= now_q + 32'd1;
            if (accept && inj_cnt_q != '1)
                inj_cnt_q <= inj_cnt_q + 1'b1;
            if (late && late_cnt_q != '1)
                late_cnt_q <= late_cnt_q + 1'b1;
            if (drop && drop_cnt_q != '1)
                drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign mem_rd_en  = (state == FETCH);
    assign mem_addr   = addr;
    assign inj_valid  = (state == INJECT);
    assign inj_src    = src_q;
    assign inj_dest   = dest_q;
    assign inj_cycle  = cyc_q;
    assign now        = now_q;
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);
    assign inj_count  = inj_cnt_q;
    assign late_count = late_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_trace_replay_ctrl.sv
// Directed bench for trace_replay_ctrl with a 1-cycle-latency trace RAM model.
module tb_trace_replay_ctrl;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   num_entries;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [39:0]       mem_rdata;
    logic              inj_valid;
    logic              inj_ready;
    logic [3:0]        inj_src;
    logic [3:0]        inj_dest;
    logic [31:0]       inj_cycle;
    logic [31:0]       now;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   inj_count;
    logic [ADDR_W:0]   late_count;
    logic [ADDR_W:0]   drop_count;

    logic [39:0] mem [0:7];
    int          rd_cnt = 0;
    int          last_addr = 0;
    int          errors = 0;
    int          checks = 0;

    trace_replay_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .num_entries(num_entries),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .inj_valid(inj_valid),
        .inj_ready(inj_ready),
        .inj_src(inj_src),
        .inj_dest(inj_dest),
        .inj_cycle(inj_cycle),
        .now(now),
        .busy(busy),
        .done(done),
        .inj_count(inj_count),
        .late_count(late_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr[2:0]];
            rd_cnt    <= rd_cnt + 1;
            last_addr <= int'(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [ADDR_W:0] n);
        num_entries = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (inj_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    bit          ok;
    bit          stable;
    int          rd0;
    logic [31:0] exp_now [3];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num_entries = '0;
        inj_ready = 1'b1;
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", {mem_rd_en, inj_valid, busy, done, inj_src,
                           inj_dest}, '0);
        check("rst_addr", mem_addr, 0);
        check("rst_now", now, 0);
        check("rst_cyc", inj_cycle, 0);
        check("rst_cnts", {inj_count, late_count, drop_count}, '0);
        rst = 1'b0;
        @(negedge clk);

        // single late entry
        mem[0] = {4'd1, 4'd3, 32'd0};
        do_start(1);
        check("t1_fetch", {mem_rd_en, busy}, 2'b11);
        check("t1_addr", mem_addr, 0);
        @(negedge clk);
        @(negedge clk);
        check("t1_wait_now", now, 2);
        check("t1_wait_v", inj_valid, 0);
        @(negedge clk);
        check("t1_valid", inj_valid, 1);
        check("t1_srcdst", {inj_src, inj_dest}, {4'd1, 4'd3});
        @(negedge clk);
        check("t1_done", {done, busy, inj_valid}, 3'b100);
        check("t1_inj", inj_count, 1);
        check("t1_late", late_count, 1);

        // three on-time entries
        mem[0] = {4'd0, 4'd5, 32'd10};
        mem[1] = {4'd2, 4'd7, 32'd20};
        mem[2] = {4'd15, 4'd1, 32'd30};
        exp_now[0] = 32'd11;
        exp_now[1] = 32'd21;
        exp_now[2] = 32'd31;
        do_start(3);
        for (int k = 0; k < 3; k++) begin
            wait_valid(40, ok);
            check("t2_seen", ok, 1);
            check("t2_now", now, exp_now[k]);
            check("t2_src", inj_src, mem[k][39:36]);
            check("t2_cyc", inj_cycle, mem[k][31:0]);
        end
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_inj", inj_count, 3);
        check("t2_late", late_count, 0);

        // backpressure
        mem[0] = {4'd4, 4'd9, 32'd5};
        inj_ready = 1'b0;
        do_start(1);
        wait_valid(20, ok);
        check("t3_seen", ok, 1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (!inj_valid || inj_src != 4'd4 || inj_dest != 4'd9 ||
                inj_cycle != 32'd5 || inj_count != 0)
                stable = 1'b0;
        end
        check("t3_stable", stable, 1);
        inj_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_done", {done, inj_valid}, 2'b10);
        check("t3_inj", inj_count, 1);

        // self-addressed drop then terminator
        mem[0] = {4'd6, 4'd6, 32'd4};
        mem[1] = {4'd1, 4'd2, 32'hFFFF_FFFF};
        mem[2] = {4'd1, 4'd2, 32'd9};
        rd0 = rd_cnt;
        do_start(5);
        wait_done(20, ok);
        check("t4_done", ok, 1);
        check("t4_drop", drop_count, 1);
        check("t4_inj", inj_count, 0);
        check("t4_reads", rd_cnt - rd0, 2);
        check("t4_lastaddr", last_addr, 1);

        // abort during WAIT_TIME
        mem[0] = {4'd3, 4'd8, 32'd50};
        do_start(1);
        repeat (4) @(negedge clk);
        check("t5_now", now, 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_idle", {busy, done, inj_valid}, 3'b000);
        repeat (2) @(negedge clk);
        check("t5_nowhold", now, 5);

        // reset during INJECT, then restart
        mem[0] = {4'd2, 4'd6, 32'd3};
        inj_ready = 1'b0;
        do_start(1);
        wait_valid(20, ok);
        check("t6_seen", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        rd0 = rd_cnt;
        check("t6_rst_outs", {inj_valid, busy, done, mem_rd_en}, 4'b0);
        check("t6_rst_vals", {now, inj_src, inj_dest, inj_cycle}, '0);
        @(negedge clk);
        rst = 1'b0;
        inj_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_noread", rd_cnt - rd0, 0);
        do_start(1);
        check("t6_refetch", {mem_rd_en, mem_addr}, {1'b1, 16'd0});
        wait_done(20, ok);
        check("t6_done", ok, 1);
        check("t6_inj", inj_count, 1);
        check("t6_late", late_count, 0);

        // empty trace
        rd0 = rd_cnt;
        do_start(0);
        check("t7_done", {done, busy}, 2'b10);
        repeat (3) @(negedge clk);
        check("t7_noread", rd_cnt - rd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
